controller_fsm: RTL and testbench
=================================

# controller_fsm

Multi-cycle control unit for the 16-bit lab processor; it consumes the word held in `instruction_register` and drives every datapath strobe. It sequences the PC, instruction-memory fetch and IR load, then decodes the opcode into data-memory, register-file and ALU controls. It is a Moore FSM whose outputs also pass through IR fields.

## Interface
- `DATA_AW`, 8, data-memory address width (IR[11:4])
- `RF_AW`, 4, register-file address width
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `instruction`  in  16  current IR contents (`instruction_register` output)
- `PC_clr`  out  1  clear program counter
- `PC_up`  out  1  increment program counter
- `IM_re`  out  1  instruction-memory read enable
- `IR_ld`  out  1  IR load strobe (drives `instruction_register` `load`)
- `D_addr`  out  DATA_AW  data-memory address
- `D_wr`  out  1  data-memory write enable
- `RF_s`  out  1  RF write-data mux: 1 = data memory, 0 = ALU
- `RF_W_addr`  out  RF_AW  RF write address
- `RF_W_en`  out  1  RF write enable
- `RF_Ra_addr`  out  RF_AW  RF read port A address
- `RF_Rb_addr`  out  RF_AW  RF read port B address
- `ALU_s0`  out  3  ALU function: 0 pass A, 1 add, 2 subtract
- `state`  out  4  current state code, for debug

## Operation
- Opcodes in IR[15:12]: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT. Codes 6–F are treated as NOOP.
- Field layout:
  - LOAD and STORE: IR[11:4] = data address, IR[3:0] = register.
  - ADD and SUB: IR[11:8] = Ra, IR[7:4] = Rb, IR[3:0] = Rc (destination).
- State codes: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- Any output not listed for a state is 0.
- INIT: PC_clr=1. Next state is FETCH.
- FETCH: IM_re=1, IR_ld=1, PC_up=1. IR captures mem[PC] at the end of the cycle. Next state is DECODE.
- DECODE: all strobes 0. Branches on `instruction`[15:12] to NOOP, STORE, LOAD_A, ADD, SUB or HALT.
- NOOP: next state is FETCH.
- LOAD_A: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0]. This state covers the 1-cycle synchronous data-memory read. Next state is LOAD_B.
- LOAD_B: same as LOAD_A, plus RF_W_en=1. Next state is FETCH.
- STORE: D_addr=IR[11:4], RF_Ra_addr=IR[3:0], D_wr=1. Next state is FETCH.
- ADD: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_W_en=1, RF_s=0, ALU_s0=1. Next state is FETCH.
- SUB: same as ADD, but ALU_s0=2.
- HALT: all strobes 0. Stays in HALT until reset.
- State register encoding is fixed as listed, so `state` is directly observable.

## Timing
- Reset: on a rising edge with `reset`=0, state goes to INIT.
  - Outputs after that edge: PC_clr=1, `state`=0, all other outputs 0.
  - While reset stays low, the FSM stays in INIT.
- Outputs are combinational from the state register and `instruction` only. There is no combinational path from `reset`.
- Consequence of reset mid-operation: a STORE cycle in progress still shows D_wr=1 until the next edge. That edge puts the FSM in INIT; no partial instruction resumes.
- Cycles per instruction, including FETCH and DECODE:
  - NOOP, STORE, ADD, SUB: 3 cycles.
  - LOAD: 4 cycles.
  - HALT: 2 cycles to enter, then terminal.
- IR timing: the IR updates at the end of FETCH. DECODE and all execute states use that new value, and it is held until the next FETCH.
- PC increments exactly once per instruction, at the end of FETCH. It never increments in HALT.
- No wait states and no handshake: memories are 1-cycle synchronous.

## Test plan
- Reset:
  - Stimulus: hold `reset`=0 for 2 edges, then release.
  - Required: during reset, `state`=0 and PC_clr=1. First edge after release: `state`=1, IR_ld=1, PC_up=1, IM_re=1.
- LOAD:
  - Stimulus: `instruction`=16'h208A.
  - Required: sequence FETCH→DECODE→LOAD_A→LOAD_B→FETCH. In LOAD_A: D_addr=8'h08, RF_W_addr=4'hA, RF_s=1, RF_W_en=0. In LOAD_B: RF_W_en=1.
- STORE:
  - Stimulus: `instruction`=16'h1F53.
  - Required: in STORE, D_addr=8'hF5, RF_Ra_addr=3, D_wr=1 for exactly 1 cycle. Then FETCH.
- ADD and SUB:
  - Stimulus: `instruction`=16'h3123, then 16'h4456.
  - Required for 3123: Ra=1, Rb=2, W_addr=3, ALU_s0=1, RF_W_en=1, RF_s=0.
  - Required for 4456: Ra=4, Rb=5, W_addr=6, ALU_s0=2.
- Illegal opcode and HALT:
  - Stimulus: `instruction`=16'hE000, then 16'h5000.
  - Required: E000 takes the NOOP path (`state` 3) with no strobes set. 5000 reaches HALT (`state`=9) and stays there for 10+ cycles with PC_up=0.
- Reset mid-instruction:
  - Stimulus: drive `reset`=0 for the edge that ends LOAD_A, and separately for the edge after HALT.
  - Required: the next state is INIT and RF_W_en never asserts. Recovery returns to FETCH in 1 cycle after release.

Source files
------------

// File: rtl/controller_fsm.sv
// Multi-cycle Moore control FSM for the 16-bit lab processor; outputs are combinational from state_q and the IR word.
// No handshake or backpressure: one state per clock, fixed 3/4-cycle instructions, HALT is terminal until reset.
module controller_fsm #(
    parameter int DATA_AW = 8,
    parameter int RF_AW   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        instruction,
    output logic               PC_clr,
    output logic               PC_up,
    output logic               IM_re,
    output logic               IR_ld,
    output logic [DATA_AW-1:0] D_addr,
    output logic               D_wr,
    output logic               RF_s,
    output logic [RF_AW-1:0]   RF_W_addr,
    output logic               RF_W_en,
    output logic [RF_AW-1:0]   RF_Ra_addr,
    output logic [RF_AW-1:0]   RF_Rb_addr,
    output logic [2:0]         ALU_s0,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    state_t state_q;
    state_t state_d;

    logic [3:0]         opcode;
    logic [DATA_AW-1:0] ir_daddr;
    logic [RF_AW-1:0]   ir_r0;
    logic [RF_AW-1:0]   ir_r1;
    logic [RF_AW-1:0]   ir_r2;

    assign opcode   = instruction[15:12];
    assign ir_daddr = instruction[4 +: DATA_AW];
    assign ir_r0    = instruction[0 +: RF_AW];
    assign ir_r1    = instruction[4 +: RF_AW];
    assign ir_r2    = instruction[8 +: RF_AW];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    4'd1:    state_d = S_STORE;
                    4'd2:    state_d = S_LOAD_A;
                    4'd3:    state_d = S_ADD;
                    4'd4:    state_d = S_SUB;
                    4'd5:    state_d = S_HALT;
                    default: state_d = S_NOOP;
                endcase
            end
            S_NOOP:   state_d = S_FETCH;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_ADD:    state_d = S_FETCH;
            S_SUB:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IM_re      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = ALU_PASS;
        case (state_q)
            S_INIT: PC_clr = 1'b1;
            S_FETCH: begin
                IM_re = 1'b1;
                IR_ld = 1'b1;
                PC_up = 1'b1;
            end
            // LOAD_A spans the synchronous data-memory read; the write lands in LOAD_B.
            S_LOAD_A, S_LOAD_B: begin
                D_addr    = ir_daddr;
                RF_s      = 1'b1;
                RF_W_addr = ir_r0;
                RF_W_en   = (state_q == S_LOAD_B);
            end
            S_STORE: begin
                D_addr     = ir_daddr;
                RF_Ra_addr = ir_r0;
                D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = ir_r2;
                RF_Rb_addr = ir_r1;
                RF_W_addr  = ir_r0;
                RF_W_en    = 1'b1;
                ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_controller_fsm.sv
// Bench for controller_fsm: instruction-level reference model feeds a per-cycle expectation queue; a negedge monitor compares.
module tb_controller_fsm;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] instruction;
    logic        PC_clr, PC_up, IM_re, IR_ld, D_wr, RF_s, RF_W_en;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state;
    logic [2:0]  ALU_s0;

    controller_fsm #(.DATA_AW(8), .RF_AW(4)) dut (
        .clock(clock), .reset(reset), .instruction(instruction),
        .PC_clr(PC_clr), .PC_up(PC_up), .IM_re(IM_re), .IR_ld(IR_ld),
        .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr),
        .RF_W_en(RF_W_en), .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr),
        .ALU_s0(ALU_s0), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_clr, pc_up, im_re, ir_ld;
        logic [7:0] d_addr;
        logic       d_wr, rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra, rb;
        logic [2:0] alu;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } sb_t;

    sb_t q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    logic [15:0] ir_model;  // what the IR holds in the model

    // Spec-level outputs for one named step of an instruction.
    function automatic exp_t expect_step(input string step, input logic [15:0] ir);
        exp_t e;
        e = '0;
        case (step)
            "INIT":   begin e.st = 4'd0; e.pc_clr = 1; end
            "FETCH":  begin e.st = 4'd1; e.im_re = 1; e.ir_ld = 1; e.pc_up = 1; end
            "DECODE": e.st = 4'd2;
            "NOOP":   e.st = 4'd3;
            "LOAD_A", "LOAD_B": begin
                e.st     = (step == "LOAD_A") ? 4'd4 : 4'd5;
                e.d_addr = ir[11:4];
                e.rf_s   = 1;
                e.w_addr = ir[3:0];
                e.w_en   = (step == "LOAD_B");
            end
            "STORE":  begin e.st = 4'd6; e.d_addr = ir[11:4]; e.ra = ir[3:0]; e.d_wr = 1; end
            "ADD", "SUB": begin
                e.st     = (step == "ADD") ? 4'd7 : 4'd8;
                e.ra     = ir[11:8];
                e.rb     = ir[7:4];
                e.w_addr = ir[3:0];
                e.w_en   = 1;
                e.alu    = (step == "ADD") ? 3'd1 : 3'd2;
            end
            "HALT":   e.st = 4'd9;
            default:  e.st = 4'hF;
        endcase
        return e;
    endfunction

    // One clock: drive this cycle's inputs, queue the outputs it must show, advance.
    task automatic tick(input logic rst_v, input string step);
        sb_t s;
        reset       = rst_v;
        instruction = ir_model;
        s.e   = expect_step(step, ir_model);
        s.tag = step;
        q.push_back(s);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // After a reset edge: extra held-low cycles, then the release cycle, all in INIT.
    task automatic init_seq(input int hold);
        for (int i = 0; i < hold; i++) tick(1'b0, "INIT");
        tick(1'b1, "INIT");
    endtask

    // Run one instruction from FETCH; reset_at = step index whose ending edge sees reset low (-1 none).
    task automatic run_instr(input logic [15:0] ir, input int reset_at, input int halt_len);
        string steps[$];
        steps = {"FETCH", "DECODE"};
        case (ir[15:12])
            4'd1: steps.push_back("STORE");
            4'd2: begin steps.push_back("LOAD_A"); steps.push_back("LOAD_B"); end
            4'd3: steps.push_back("ADD");
            4'd4: steps.push_back("SUB");
            4'd5: for (int i = 0; i < halt_len; i++) steps.push_back("HALT");
            default: steps.push_back("NOOP");
        endcase
        for (int i = 0; i < steps.size(); i++) begin
            if (i == 1) ir_model = ir;  // IR captured at the end of FETCH
            tick((i == reset_at) ? 1'b0 : 1'b1, steps[i]);
            if (i == reset_at) begin
                init_seq(0);
                return;
            end
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            sb_t  s;
            exp_t act;
            s   = q.pop_front();
            act = '{state, PC_clr, PC_up, IM_re, IR_ld, D_addr, D_wr, RF_s,
                    RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0};
            n_checks++;
            if (act === s.e) n_pass++;
            else $display("FAIL cyc%0d %s ir=%h: got %h required %h",
                          cyc, s.tag, instruction, act, s.e);
        end
    end

    initial begin
        logic [15:0] r;
        int          op, len, ra;
        reset       = 1'b0;
        instruction = 16'h0000;
        ir_model    = 16'h0000;
        @(posedge clock);
        #1;
        init_seq(1);

        run_instr(16'h208A, -1, 0);
        run_instr(16'h1F53, -1, 0);
        run_instr(16'h3123, -1, 0);
        run_instr(16'h4456, -1, 0);
        run_instr(16'hE000, -1, 0);
        run_instr(16'h208A, 2, 0);     // reset on the edge ending LOAD_A
        run_instr(16'h5000, 13, 12);   // HALT held 12 cycles, then reset
        run_instr(16'h1F53, 2, 0);     // reset while STORE shows D_wr

        for (int n = 0; n < 200; n++) begin
            r   = 16'($urandom);
            op  = $urandom_range(0, 7);
            if (op < 6) r[15:12] = 4'(op);
            len = $urandom_range(1, 12);
            ra  = -1;
            if (r[15:12] == 4'd5) ra = len + 1;
            else if ($urandom_range(0, 7) == 0) ra = $urandom_range(0, 3);
            run_instr(r, ra, len);
            if (ra >= 0 && $urandom_range(0, 3) == 0) begin
                // extra held-low reset pulse while sitting in INIT is covered by re-entering via reset
                run_instr(16'h0000, 0, 0);
            end
        end

        @(posedge clock);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
